// File: rtl/adder_share_sequencer.sv
// Two-requester arbiter around one SLICE-bit adder, sequenced LSB slice
// first with a registered carry; one operation in flight at a time.
module adder_share_sequencer #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_carryout,
    output logic             resp_overflow,
    output logic             resp_id,
    output logic             busy
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic             id_q;
    logic             co_q;
    logic             ov_q;
    logic             ptr_q;
    logic             resp_valid_q;

    logic             g0, g1;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_sub;
    int               base;
    logic [SLICE-1:0] a_sl, b_sl;
    logic [SLICE:0]   tot;
    logic             cin_msb;
    logic             last;

    // ptr_q = 1 means req1 wins a tie; reset leaves req0 favoured
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (req0_valid && !req1_valid) begin
            g0 = 1'b1;
        end else if (!req0_valid && req1_valid) begin
            g1 = 1'b1;
        end else if (req0_valid && req1_valid) begin
            if (ptr_q) g1 = 1'b1;
            else       g0 = 1'b1;
        end
    end

    assign req0_ready = rst_n && (state_q == IDLE) && g0;
    assign req1_ready = rst_n && (state_q == IDLE) && g1;

    always_comb begin
        sel_a   = g1 ? req1_a   : req0_a;
        sel_b   = g1 ? req1_b   : req0_b;
        sel_sub = g1 ? req1_sub : req0_sub;
    end

    always_comb begin
        base    = int'(idx_q) * SLICE;
        a_sl    = a_q[base +: SLICE];
        b_sl    = b_q[base +: SLICE];
        tot     = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
        cin_msb = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ tot[SLICE-1];
        last    = (idx_q == IW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            id_q         <= 1'b0;
            co_q         <= 1'b0;
            ov_q         <= 1'b0;
            ptr_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (g0 || g1) begin
                        a_q     <= sel_a;
                        b_q     <= sel_sub ? ~sel_b : sel_b;
                        carry_q <= sel_sub;
                        id_q    <= g1;
                        ptr_q   <= g0;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[base +: SLICE] <= tot[SLICE-1:0];
                    carry_q              <= tot[SLICE];
                    if (last) begin
                        co_q         <= tot[SLICE];
                        ov_q         <= cin_msb ^ tot[SLICE];
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_sum      = sum_q;
    assign resp_carryout = co_q;
    assign resp_overflow = ov_q;
    assign resp_id       = id_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_sequencer.sv
// Directed bench for adder_share_sequencer with a result scoreboard.
// Expected results are queued at request time and checked on response.
module tb_adder_share_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_sub = 1'b0, req1_sub = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] resp_sum;
    logic         resp_carryout, resp_overflow, resp_id, busy;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        logic         id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    adder_share_sequencer #(.WIDTH(W), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_carryout(resp_carryout),
        .resp_overflow(resp_overflow), .resp_id(resp_id), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, b,
                                   input logic sub, input logic id);
        exp_t e;
        logic [W-1:0] bp;
        logic [W:0]   full;
        bp   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, sub};
        e.sum = full[W-1:0];
        e.co  = full[W];
        e.ov  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
        e.id  = id;
        return e;
    endfunction

    // Returns at the negedge one cycle after the accepting edge.
    task automatic issue(input logic id, input logic [W-1:0] a, b,
                         input logic sub, input exp_t e);
        bit ok = 0;
        if (id) begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("issue_accept", 32'(ok), 32'd1);
        if (ok) sb.push_back(e);
        @(negedge clk);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_resp(output int waited, output bit ok);
        ok = 0;
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            if (resp_valid === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            waited++;
        end
        check("resp_timeout", 32'(ok), 32'd1);
    endtask

    task automatic cmp_resp(input string tag, input exp_t e);
        check({tag, "_sum"}, 32'(resp_sum), 32'(e.sum));
        check({tag, "_co"}, 32'(resp_carryout), 32'(e.co));
        check({tag, "_ov"}, 32'(resp_overflow), 32'(e.ov));
        check({tag, "_id"}, 32'(resp_id), 32'(e.id));
    endtask

    task automatic collect(input string tag);
        int   w;
        bit   ok;
        exp_t e;
        wait_resp(w, ok);
        if (!ok) return;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        cmp_resp(tag, e);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        int   w, ng, nr;
        bit   ok;
        logic exp_g;
        exp_t e;

        #2;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(resp_sum), 32'd0);
        check("rst_flags",
              32'({resp_carryout, resp_overflow, resp_id}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: latency and basic add
        issue(1'b0, 16'h00FF, 16'h0001, 1'b0, '{16'h0100, 0, 0, 0});
        wait_resp(w, ok);
        check("latency", 32'(w + 1), 32'd5);
        check("busy_done", 32'(busy), 32'd1);
        if (ok) begin
            e = sb.pop_front();
            cmp_resp("t1", e);
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end

        // 2: overflow and carry-out
        issue(1'b1, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 0, 1, 1});
        collect("t2a");
        issue(1'b1, 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1, 0, 1});
        collect("t2b");

        // 3: subtract borrow and overflow
        issue(1'b0, 16'h0000, 16'h0001, 1'b1, '{16'hFFFF, 0, 0, 0});
        collect("t3a");
        issue(1'b1, 16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1, 1, 1});
        collect("t3b");

        // 4: round robin, reset pointer first
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        req0_a = 16'h1234; req0_b = 16'h1111; req0_sub = 1'b0;
        req1_a = 16'h5000; req1_b = 16'h6000; req1_sub = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        ng = 0;
        nr = 0;
        exp_g = 1'b0;
        for (int k = 0; k < 60 && nr < 4; k++) begin
            if (ng >= 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            if (req0_ready && req1_ready)
                check("rr_both_ready", 32'd1, 32'd0);
            if (req0_ready || req1_ready) begin
                check("rr_grant", 32'(req1_ready), 32'(exp_g));
                if (req1_ready) sb.push_back(model(req1_a, req1_b, 1'b1, 1'b1));
                else            sb.push_back(model(req0_a, req0_b, 1'b0, 1'b0));
                ng++;
                exp_g = ~exp_g;
            end
            if (resp_valid) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    cmp_resp("rr", e);
                end else begin
                    check("rr_sb_empty", 32'd1, 32'd0);
                end
                nr++;
            end
            @(negedge clk);
        end
        check("rr_resp_count", 32'(nr), 32'd4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        sb.delete();
        @(negedge clk);

        // 5: hold in DONE with backpressure
        issue(1'b0, 16'hA5A5, 16'h0F0F, 1'b1, model(16'hA5A5, 16'h0F0F, 1'b1, 1'b0));
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_resp(w, ok);
        if (ok) begin
            e = sb.pop_front();
            for (int k = 0; k < 4; k++) begin
                cmp_resp("hold", e);
                check("hold_valid", 32'(resp_valid), 32'd1);
                check("hold_busy", 32'(busy), 32'd1);
                check("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
                if (k < 3) @(negedge clk);
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            check("hold_release_valid", 32'(resp_valid), 32'd0);
            check("hold_release_busy", 32'(busy), 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // 6: reset mid-run at slice index 2
        issue(1'b0, 16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", 32'({req0_ready, req1_ready}), 32'b10);
        sb.push_back(model(req0_a, req0_b, req0_sub, 1'b0));
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        collect("post_rst");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
